// File: rtl/cc_cond_unit.sv
// Execute-stage condition-code register, jXX/cmovXX condition evaluation and the E->M
// pipeline register with stall/bubble control.
module cc_cond_unit #(
  parameter int unsigned W         = 64,
  parameter logic [3:0]  RNONE     = 4'hF,
  parameter logic [3:0]  ICODE_NOP = 4'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic         alu_zf,
  input  logic         alu_sf,
  input  logic         alu_of,
  input  logic         m_exc,
  input  logic         w_exc,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         e_cnd,
  output logic [3:0]   e_dstE_out,
  output logic         M_valid,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [3:0]   M_dstE
);

  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] ICODE_OPQ  = 4'h6;
  localparam logic [3:0] ICODE_JXX  = 4'h7;

  logic         r_zf, r_sf, r_of;
  logic         r_m_valid;
  logic [3:0]   r_m_icode;
  logic         r_m_cnd;
  logic [W-1:0] r_m_valE;
  logic [3:0]   r_m_dstE;

  logic         w_set_cc;
  logic         w_cond;
  logic         w_cnd;
  logic [3:0]   w_dstE;

  // CC only updates for an OPq that will actually move on to M without a pending exception.
  assign w_set_cc = e_valid & (e_icode == ICODE_OPQ) & ~m_exc & ~w_exc & ~m_stall & ~m_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_set_cc) begin
      r_zf <= alu_zf;
      r_sf <= alu_sf;
      r_of <= alu_of;
    end
  end

  always_comb begin
    w_cond = 1'b0;
    case (e_ifun)
      4'h0:    w_cond = 1'b1;
      4'h1:    w_cond = (r_sf ^ r_of) | r_zf;
      4'h2:    w_cond = r_sf ^ r_of;
      4'h3:    w_cond = r_zf;
      4'h4:    w_cond = ~r_zf;
      4'h5:    w_cond = ~(r_sf ^ r_of);
      4'h6:    w_cond = ~(r_sf ^ r_of) & ~r_zf;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_cnd  = e_valid & ((e_icode == ICODE_CMOV) | (e_icode == ICODE_JXX)) & w_cond;
  // A not-taken cmov must not write its destination.
  assign w_dstE = ((e_icode == ICODE_CMOV) && !w_cnd) ? RNONE : e_dstE;

  always_ff @(posedge clk) begin
    if (rst || m_bubble) begin
      r_m_valid <= 1'b0;
      r_m_icode <= ICODE_NOP;
      r_m_cnd   <= 1'b0;
      r_m_valE  <= '0;
      r_m_dstE  <= RNONE;
    end else if (!m_stall) begin
      r_m_valid <= e_valid;
      r_m_icode <= e_icode;
      r_m_cnd   <= w_cnd;
      r_m_valE  <= e_valE;
      r_m_dstE  <= w_dstE;
    end
  end

  assign cc_zf      = r_zf;
  assign cc_sf      = r_sf;
  assign cc_of      = r_of;
  assign e_cnd      = w_cnd;
  assign e_dstE_out = w_dstE;
  assign M_valid    = r_m_valid;
  assign M_icode    = r_m_icode;
  assign M_cnd      = r_m_cnd;
  assign M_valE     = r_m_valE;
  assign M_dstE     = r_m_dstE;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed bench for cc_cond_unit: CC update gating, condition decode, cmov squash and M register.
module tb_cc_cond_unit;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         e_valid;
  logic [3:0]   e_icode, e_ifun, e_dstE;
  logic [W-1:0] e_valE;
  logic         alu_zf, alu_sf, alu_of;
  logic         m_exc, w_exc, m_stall, m_bubble;
  logic         cc_zf, cc_sf, cc_of, e_cnd;
  logic [3:0]   e_dstE_out;
  logic         M_valid, M_cnd;
  logic [3:0]   M_icode, M_dstE;
  logic [W-1:0] M_valE;

  int n_chk  = 0;
  int n_fail = 0;

  cc_cond_unit #(.W(W), .RNONE(4'hF), .ICODE_NOP(4'h1)) dut (
    .clk        (clk),
    .rst        (rst),
    .e_valid    (e_valid),
    .e_icode    (e_icode),
    .e_ifun     (e_ifun),
    .e_dstE     (e_dstE),
    .e_valE     (e_valE),
    .alu_zf     (alu_zf),
    .alu_sf     (alu_sf),
    .alu_of     (alu_of),
    .m_exc      (m_exc),
    .w_exc      (w_exc),
    .m_stall    (m_stall),
    .m_bubble   (m_bubble),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of),
    .e_cnd      (e_cnd),
    .e_dstE_out (e_dstE_out),
    .M_valid    (M_valid),
    .M_icode    (M_icode),
    .M_cnd      (M_cnd),
    .M_valE     (M_valE),
    .M_dstE     (M_dstE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] dst, input logic [63:0] val,
                       input logic zf, input logic sf, input logic of);
    e_valid = v; e_icode = ic; e_ifun = fn; e_dstE = dst; e_valE = val;
    alu_zf = zf; alu_sf = sf; alu_of = of;
    #1;
  endtask

  initial begin
    rst = 1'b1; m_exc = 1'b0; w_exc = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("rst_M_valid", M_valid, 1'b0);
    chk("rst_M_icode", M_icode, 4'h1);
    chk("rst_M_cnd", M_cnd, 1'b0);
    chk("rst_M_valE", M_valE, 64'h0);
    chk("rst_M_dstE", M_dstE, 4'hF);
    rst = 1'b0;

    // je after reset: ZF=1
    drive(1'b1, 4'h7, 4'h3, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("je_reset_cnd", e_cnd, 1'b1);

    // OPq sets CC={0,1,0}
    drive(1'b1, 4'h6, 4'h0, 4'h2, 64'h5, 1'b0, 1'b1, 1'b0);
    chk("opq_cnd", e_cnd, 1'b0);
    chk("opq_dst", e_dstE_out, 4'h2);
    tick();
    chk("opq_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
    chk("opq_M_icode", M_icode, 4'h6);
    chk("opq_M_valE", M_valE, 64'h5);

    // jl uses registered CC, not the same-cycle ALU flags
    drive(1'b1, 4'h7, 4'h2, 4'hF, 64'h0, 1'b1, 1'b0, 1'b0);
    chk("jl_cnd", e_cnd, 1'b1);
    tick();
    chk("jl_M_cnd", M_cnd, 1'b1);
    chk("jl_cc_hold", {cc_zf, cc_sf, cc_of}, 3'b010);
    drive(1'b1, 4'h7, 4'h5, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("jge_cnd", e_cnd, 1'b0);

    // cmovg not taken with CC={0,1,0}
    drive(1'b1, 4'h2, 4'h6, 4'h3, 64'h11, 1'b0, 1'b0, 1'b0);
    chk("cmovg_nt_cnd", e_cnd, 1'b0);
    chk("cmovg_nt_dst", e_dstE_out, 4'hF);
    tick();
    chk("cmovg_nt_M_dstE", M_dstE, 4'hF);

    // CC={0,0,0} then cmovg taken
    drive(1'b1, 4'h6, 4'h1, 4'h5, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("opq0_cc", {cc_zf, cc_sf, cc_of}, 3'b000);
    drive(1'b1, 4'h2, 4'h6, 4'h3, 64'h22, 1'b0, 1'b0, 1'b0);
    chk("cmovg_t_cnd", e_cnd, 1'b1);
    chk("cmovg_t_dst", e_dstE_out, 4'h3);
    tick();
    chk("cmovg_t_M_dstE", M_dstE, 4'h3);

    // Exceptions freeze CC but M still loads
    m_exc = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 4'h6, 64'h33, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mexc_cc", {cc_zf, cc_sf, cc_of}, 3'b000);
    chk("mexc_M_valE", M_valE, 64'h33);
    m_exc = 1'b0; w_exc = 1'b1;
    tick();
    chk("wexc_cc", {cc_zf, cc_sf, cc_of}, 3'b000);
    w_exc = 1'b0;
    tick();
    chk("noexc_cc", {cc_zf, cc_sf, cc_of}, 3'b100);

    // Stall holds M and blocks CC update
    drive(1'b1, 4'h2, 4'h0, 4'h4, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load_M_valE", M_valE, 64'hDEAD_BEEF);
    chk("load_M_dstE", M_dstE, 4'h4);
    m_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h6, 4'h0, 4'(i), 64'(i + 100), 1'b0, 1'b1, 1'b1);
      tick();
      chk("stall_M_valE", M_valE, 64'hDEAD_BEEF);
      chk("stall_M_icode", M_icode, 4'h2);
    end
    chk("stall_cc", {cc_zf, cc_sf, cc_of}, 3'b100);

    // Bubble wins over stall; CC untouched
    m_bubble = 1'b1;
    drive(1'b1, 4'h6, 4'h0, 4'h7, 64'h44, 1'b0, 1'b0, 1'b1);
    tick();
    chk("bub_M_icode", M_icode, 4'h1);
    chk("bub_M_dstE", M_dstE, 4'hF);
    chk("bub_M_valid", M_valid, 1'b0);
    chk("bub_M_valE", M_valE, 64'h0);
    chk("bub_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    m_stall = 1'b0; m_bubble = 1'b0;

    // Reset overrides a concurrent OPq
    drive(1'b1, 4'h7, 4'h0, 4'hF, 64'h7, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_M_valid", M_valid, 1'b1);
    chk("pre_rst_M_cnd", M_cnd, 1'b1);
    drive(1'b1, 4'h6, 4'h0, 4'h8, 64'h55, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
    chk("midrst_M_valid", M_valid, 1'b0);
    chk("midrst_M_icode", M_icode, 4'h1);
    chk("midrst_M_cnd", M_cnd, 1'b0);
    chk("midrst_M_valE", M_valE, 64'h0);
    chk("midrst_M_dstE", M_dstE, 4'hF);

    // Decode corners with CC={1,0,0}
    drive(1'b1, 4'h7, 4'h9, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("ifun9_cnd", e_cnd, 1'b0);
    drive(1'b1, 4'h7, 4'h1, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("jle_cnd", e_cnd, 1'b1);
    drive(1'b1, 4'h7, 4'h4, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("jne_cnd", e_cnd, 1'b0);
    drive(1'b1, 4'h7, 4'h6, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("jg_cnd", e_cnd, 1'b0);
    drive(1'b0, 4'h7, 4'h0, 4'hF, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("invalid_cnd", e_cnd, 1'b0);
    drive(1'b1, 4'h3, 4'h0, 4'h9, 64'h0, 1'b0, 1'b0, 1'b0);
    chk("other_icode_cnd", e_cnd, 1'b0);
    chk("other_icode_dst", e_dstE_out, 4'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_cond_unit.md
Name: cc_cond_unit

Overview:
- Consumer side of the execute-stage ALU flag interface.
- Latches ZF/SF/OF produced by the ALU into the architectural condition-code register.
- Evaluates jXX/cmovXX conditions from the current CC and squashes the destination of not-taken cmov.
- Registers the E→M pipeline fields (icode, Cnd, valE, dstE) with stall/bubble control; sits between the ALU and the memory stage in the pipelined core.

Parameters:
- W, 64, datapath width of valE.
- RNONE, 4'hF, register ID meaning "no destination".
- ICODE_NOP, 4'h1, icode inserted on bubble.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- e_valid  in  1  execute stage holds a real instruction
- e_icode  in  4  execute-stage icode
- e_ifun  in  4  execute-stage ifun
- e_dstE  in  4  execute-stage destination register ID
- e_valE  in  W  ALU result
- alu_zf  in  1  ALU zero flag
- alu_sf  in  1  ALU sign flag
- alu_of  in  1  ALU overflow flag
- m_exc  in  1  instruction now in M has an exception status
- w_exc  in  1  instruction now in W has an exception status
- m_stall  in  1  hold M pipeline register
- m_bubble  in  1  load bubble into M pipeline register
- cc_zf  out  1  architectural ZF
- cc_sf  out  1  architectural SF
- cc_of  out  1  architectural OF
- e_cnd  out  1  combinational condition result for the E instruction
- e_dstE_out  out  4  combinational dstE after cmov squash
- M_valid  out  1  registered
- M_icode  out  4  registered
- M_cnd  out  1  registered
- M_valE  out  W  registered
- M_dstE  out  4  registered

Behaviour:
- Reset (rst high at a clk edge):
  - cc_zf=1, cc_sf=0, cc_of=0.
  - M_valid=0, M_icode=ICODE_NOP, M_cnd=0, M_valE=0, M_dstE=RNONE.
  - rst has priority over every other input.
- set_cc = e_valid & (e_icode==4'h6) & ~m_exc & ~w_exc & ~m_stall & ~m_bubble.
  - When set_cc is high, CC <= {alu_zf, alu_sf, alu_of} at the edge. Otherwise CC holds.
- Condition evaluation is combinational and uses the current registered CC, never the ALU flags of the same cycle. By e_ifun:
  - 0 (always): 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): ~ZF
  - 5 (ge): ~(SF^OF)
  - 6 (g): ~(SF^OF)&~ZF
  - 7–15: 0
- e_cnd:
  - Equals the evaluated condition when e_icode is 2 (cmovXX/rrmovq) or 7 (jXX).
  - Is 0 for all other icodes.
  - Is forced to 0 when e_valid=0.
- e_dstE_out = RNONE when e_icode==2 and e_cnd==0; otherwise e_dstE.
- M register update at each clk edge, priority rst > m_bubble > m_stall > load:
  - Bubble: same values as reset for the M fields only; CC is unaffected.
  - Stall: all M fields hold.
  - Load: M_valid<=e_valid, M_icode<=e_icode, M_cnd<=e_cnd, M_valE<=e_valE, M_dstE<=e_dstE_out.
- Latency:
  - e_cnd and e_dstE_out: 0 cycles.
  - M fields and CC: 1 cycle.
  - An OPq updates CC at the edge ending its E cycle, so a jXX immediately following it sees the new CC in its own E cycle.
- Simultaneous events:
  - m_stall and m_bubble both high: bubble wins, and CC is not updated.
  - m_exc or w_exc high: CC is frozen, but the M register still loads normally.
- Reset mid-operation: any pending CC update is discarded; CC takes the reset values.

Test Plan:
- Reset, then e_icode=7, e_ifun=3 (je), e_valid=1 → e_cnd=1 (ZF reset=1); cc={1,0,0}.
- OPq with alu flags zf=0, sf=1, of=0, no exceptions, then jl (ifun 2) on the next cycle → CC={0,1,0}, e_cnd=1, M_cnd=1 one cycle later. jge (ifun 5) with the same CC → e_cnd=0.
- cmovg (icode 2, ifun 6) with CC={0,1,0}, e_dstE=4'h3 → e_cnd=0, e_dstE_out=4'hF, M_dstE=4'hF after the edge. With CC={0,0,0}: M_dstE=4'h3.
- OPq with alu zf=1 while m_exc=1 → CC unchanged. Repeat with w_exc=1 → unchanged. Repeat with both low → cc_zf=1.
- Load M with valE=64'hDEAD_BEEF, then m_stall=1 for 3 cycles while inputs change → M_valE stays 64'hDEAD_BEEF. Then m_stall=1 and m_bubble=1 together → M_icode=1, M_dstE=F, M_valid=0, and CC is not updated by the concurrent OPq.
- OPq with flags {0,0,1} and rst=1 asserted in the same cycle → CC={1,0,0}, all M fields at reset values. Also cover ifun=4'h9 on jXX → e_cnd=0.
